// File: rtl/fdma_pkg_ram_responder.sv
// FDMA package-interface responder backed by on-chip RAM instead of PS DDR.
// Serialises pkg_wr/pkg_rd requests with programmable latency and burst gaps.
module fdma_pkg_ram_responder #(
    parameter int unsigned MEM_AW    = 12,
    parameter logic [31:0] DDR_BASE  = 32'h0100_0000,
    parameter int unsigned WR_LAT    = 4,
    parameter int unsigned RD_LAT    = 8,
    parameter int unsigned BURST_LEN = 256,
    parameter int unsigned GAP_CYC   = 2
) (
    input  logic        ui_clk,
    input  logic        ui_rstn,
    input  logic [31:0] pkg_wr_addr,
    input  logic        pkg_wr_areq,
    input  logic [31:0] pkg_wr_size,
    input  logic [31:0] pkg_wr_data,
    output logic        pkg_wr_en,
    output logic        pkg_wr_last,
    input  logic [31:0] pkg_rd_addr,
    input  logic        pkg_rd_areq,
    input  logic [31:0] pkg_rd_size,
    output logic [31:0] pkg_rd_data,
    output logic        pkg_rd_en,
    output logic        pkg_rd_last,
    output logic        busy,
    output logic        req_drop
);

    typedef enum logic [3:0] {
        IDLE, WR_WAIT, WR_DATA, WR_GAP, WR_DONE,
        RD_WAIT, RD_DATA, RD_GAP, RD_DONE
    } state_t;

    localparam logic [31:0]       WLAT    = 32'(WR_LAT);
    localparam logic [31:0]       RLAT    = 32'(RD_LAT);
    localparam logic [31:0]       BLEN_M1 = 32'(BURST_LEN - 1);
    localparam logic [31:0]       GAP     = 32'(GAP_CYC);
    localparam logic [MEM_AW-1:0] IDX_ONE = MEM_AW'(1);

    logic [31:0] mem [0:(1<<MEM_AW)-1];

    state_t             state_q, state_d;
    logic               wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
    logic [31:0]        wr_addr_q, wr_addr_d, wr_size_q, wr_size_d;
    logic [31:0]        rd_addr_q, rd_addr_d, rd_size_q, rd_size_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [31:0]        rem_q, rem_d;
    logic [31:0]        burst_q, burst_d;
    logic [MEM_AW-1:0]  idx_q, idx_d;
    logic               drop_q, drop_d;
    logic [31:0]        rd_data_q;
    logic [MEM_AW-1:0]  wr_idx, rd_idx;
    logic [31:0]        wr_wait_tgt, rd_wait_tgt, wr_first_tgt, rd_first_tgt;
    logic               wr_dispatch, rd_dispatch;

    assign wr_idx = MEM_AW'((wr_addr_q - DDR_BASE) >> 2);
    assign rd_idx = MEM_AW'((rd_addr_q - DDR_BASE) >> 2);

    // A zero-length transfer waits one extra cycle so last lands at LAT+1 after dispatch.
    assign wr_first_tgt = (wr_size_q == '0) ? WLAT : WLAT - 32'd1;
    assign rd_first_tgt = (rd_size_q == '0) ? RLAT : RLAT - 32'd1;
    assign wr_wait_tgt  = (rem_q == '0) ? WLAT : WLAT - 32'd1;
    assign rd_wait_tgt  = (rem_q == '0) ? RLAT : RLAT - 32'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        burst_d     = burst_q;
        idx_d       = idx_q;
        wr_dispatch = 1'b0;
        rd_dispatch = 1'b0;
        wr_pend_d   = wr_pend_q;
        wr_addr_d   = wr_addr_q;
        wr_size_d   = wr_size_q;
        rd_pend_d   = rd_pend_q;
        rd_addr_d   = rd_addr_q;
        rd_size_d   = rd_size_q;
        drop_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_pend_q) begin
                    wr_dispatch = 1'b1;
                    idx_d       = wr_idx;
                    rem_d       = wr_size_q;
                    cnt_d       = '0;
                    burst_d     = '0;
                    state_d     = (wr_first_tgt == '0) ? WR_DATA : WR_WAIT;
                end else if (rd_pend_q) begin
                    rd_dispatch = 1'b1;
                    idx_d       = rd_idx;
                    rem_d       = rd_size_q;
                    cnt_d       = '0;
                    burst_d     = '0;
                    state_d     = RD_WAIT;
                end
            end
            WR_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == wr_wait_tgt - 32'd1)
                    state_d = (rem_q == '0) ? WR_DONE : WR_DATA;
            end
            WR_DATA: begin
                idx_d   = idx_q + IDX_ONE;
                rem_d   = rem_q - 32'd1;
                burst_d = (burst_q == BLEN_M1) ? '0 : burst_q + 32'd1;
                cnt_d   = '0;
                if (rem_q == 32'd1)
                    state_d = WR_DONE;
                else if (burst_q == BLEN_M1 && GAP != '0)
                    state_d = WR_GAP;
            end
            WR_GAP: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == GAP - 32'd1)
                    state_d = WR_DATA;
            end
            WR_DONE: state_d = IDLE;
            RD_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == rd_wait_tgt - 32'd1)
                    state_d = (rem_q == '0) ? RD_DONE : RD_DATA;
            end
            RD_DATA: begin
                idx_d   = idx_q + IDX_ONE;
                rem_d   = rem_q - 32'd1;
                burst_d = (burst_q == BLEN_M1) ? '0 : burst_q + 32'd1;
                cnt_d   = '0;
                if (rem_q == 32'd1)
                    state_d = RD_DONE;
                else if (burst_q == BLEN_M1 && GAP != '0)
                    state_d = RD_GAP;
            end
            RD_GAP: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == GAP - 32'd1)
                    state_d = RD_DATA;
            end
            RD_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A pending slot already holding a request keeps it and reports the loss.
        if (pkg_wr_areq) begin
            if (wr_pend_q) begin
                drop_d = 1'b1;
            end else begin
                wr_pend_d = 1'b1;
                wr_addr_d = pkg_wr_addr;
                wr_size_d = pkg_wr_size;
            end
        end
        if (pkg_rd_areq) begin
            if (rd_pend_q) begin
                drop_d = 1'b1;
            end else begin
                rd_pend_d = 1'b1;
                rd_addr_d = pkg_rd_addr;
                rd_size_d = pkg_rd_size;
            end
        end
        if (wr_dispatch) wr_pend_d = 1'b0;
        if (rd_dispatch) rd_pend_d = 1'b0;
    end

    always_ff @(posedge ui_clk or negedge ui_rstn) begin
        if (!ui_rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            burst_q   <= '0;
            idx_q     <= '0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_size_q <= '0;
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
            rd_size_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            burst_q   <= burst_d;
            idx_q     <= idx_d;
            wr_pend_q <= wr_pend_d;
            wr_addr_q <= wr_addr_d;
            wr_size_q <= wr_size_d;
            rd_pend_q <= rd_pend_d;
            rd_addr_q <= rd_addr_d;
            rd_size_q <= rd_size_d;
            drop_q    <= drop_d;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (state_q == WR_DATA)
            mem[idx_q] <= pkg_wr_data;
    end

    // Read address is fetched on the edge entering each beat so data aligns with rd_en.
    always_ff @(posedge ui_clk or negedge ui_rstn) begin
        if (!ui_rstn)
            rd_data_q <= '0;
        else if (state_d == RD_DATA)
            rd_data_q <= mem[idx_d];
    end

    assign pkg_wr_en   = (state_q == WR_DATA);
    assign pkg_wr_last = (state_q == WR_DONE);
    assign pkg_rd_en   = (state_q == RD_DATA);
    assign pkg_rd_last = (state_q == RD_DONE);
    assign pkg_rd_data = rd_data_q;
    assign req_drop    = drop_q;
    assign busy        = (state_q != IDLE) | wr_pend_q | rd_pend_q;

endmodule

// File: tb/tb_fdma_pkg_ram_responder.sv
// Directed bench for fdma_pkg_ram_responder: timing, gaps, ordering, drops, wrap, reset.
module tb_fdma_pkg_ram_responder;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        ui_clk = 1'b0;
    logic        ui_rstn = 1'b0;
    logic [31:0] pkg_wr_addr = '0, pkg_wr_size = '0, pkg_wr_data = '0;
    logic        pkg_wr_areq = 1'b0;
    logic        pkg_wr_en, pkg_wr_last;
    logic [31:0] pkg_rd_addr = '0, pkg_rd_size = '0;
    logic        pkg_rd_areq = 1'b0;
    logic [31:0] pkg_rd_data;
    logic        pkg_rd_en, pkg_rd_last, busy, req_drop;

    fdma_pkg_ram_responder #(
        .MEM_AW(12), .DDR_BASE(BASE), .WR_LAT(4), .RD_LAT(8),
        .BURST_LEN(256), .GAP_CYC(2)
    ) dut (
        .ui_clk(ui_clk), .ui_rstn(ui_rstn),
        .pkg_wr_addr(pkg_wr_addr), .pkg_wr_areq(pkg_wr_areq),
        .pkg_wr_size(pkg_wr_size), .pkg_wr_data(pkg_wr_data),
        .pkg_wr_en(pkg_wr_en), .pkg_wr_last(pkg_wr_last),
        .pkg_rd_addr(pkg_rd_addr), .pkg_rd_areq(pkg_rd_areq),
        .pkg_rd_size(pkg_rd_size), .pkg_rd_data(pkg_rd_data),
        .pkg_rd_en(pkg_rd_en), .pkg_rd_last(pkg_rd_last),
        .busy(busy), .req_drop(req_drop)
    );

    always #5 ui_clk = ~ui_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    int idle_cyc = 0;
    bit timed_out = 0;
    int wr_cyc[$];
    int rd_cyc[$];
    int wl_cyc[$];
    int rl_cyc[$];
    logic [31:0] rd_dat[$];

    int n_wr_en = 0, n_wr_last = 0, n_rd_en = 0, n_rd_last = 0, n_drop = 0, n_overlap = 0;

    always @(negedge ui_clk) begin
        if (pkg_wr_en)   n_wr_en++;
        if (pkg_wr_last) n_wr_last++;
        if (pkg_rd_en)   n_rd_en++;
        if (pkg_rd_last) n_rd_last++;
        if (req_drop)    n_drop++;
        if ((pkg_wr_en | pkg_wr_last) & (pkg_rd_en | pkg_rd_last)) n_overlap++;
        if ((pkg_wr_en & pkg_wr_last) | (pkg_rd_en & pkg_rd_last)) n_overlap++;
    end

    task automatic tick();
        @(posedge ui_clk);
        #1;
        cyc++;
    endtask

    // Runs the bus until busy falls, recording beat/last cycles relative to t0.
    task automatic run_until_idle(input logic [31:0] wbase, input int budget);
        int nw;
        bit done;
        nw = 0;
        done = 0;
        timed_out = 0;
        wr_cyc.delete(); rd_cyc.delete(); wl_cyc.delete(); rl_cyc.delete(); rd_dat.delete();
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            pkg_wr_areq = 1'b0;
            pkg_rd_areq = 1'b0;
            if (pkg_wr_en) begin
                wr_cyc.push_back(cyc - t0);
                pkg_wr_data = wbase + 32'(nw);
                nw++;
            end
            if (pkg_rd_en) begin
                rd_cyc.push_back(cyc - t0);
                rd_dat.push_back(pkg_rd_data);
            end
            if (pkg_wr_last) wl_cyc.push_back(cyc - t0);
            if (pkg_rd_last) rl_cyc.push_back(cyc - t0);
            if (!busy) begin
                idle_cyc = cyc - t0;
                done = 1;
            end
        end
        if (!done) timed_out = 1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({pkg_wr_en, pkg_wr_last, pkg_rd_en, pkg_rd_last, busy, req_drop} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {pkg_wr_en, pkg_wr_last, pkg_rd_en, pkg_rd_last, busy, req_drop});
        end
        checks++;
        if (pkg_rd_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_rd_data: got %h expected 00000000", pkg_rd_data);
        end
        ui_rstn = 1'b1;
        tick();
    endtask

    task automatic test_long_burst();
        int bad;
        int first;
        int mism;
        logic [31:0] bad_val;
        int bad_pos;
        pkg_wr_addr = BASE; pkg_wr_size = 32'd1024; pkg_wr_areq = 1'b1; t0 = cyc;
        run_until_idle(32'd0, 3000);
        checks++;
        if (timed_out !== 1'b0) begin failures++; $display("FAIL wr1024_timeout: busy stuck after 3000 cycles"); end
        checks++;
        if (wr_cyc.size() !== 1024) begin failures++; $display("FAIL wr1024_beats: got %0d expected 1024", wr_cyc.size()); end
        first = (wr_cyc.size() > 0) ? wr_cyc[0] : -1;
        checks++;
        if (first !== 5) begin failures++; $display("FAIL wr1024_first: got %0d expected 5", first); end
        bad = 0;
        for (int i = 1; i < wr_cyc.size(); i++)
            if (wr_cyc[i] - wr_cyc[i-1] != ((i % 256 == 0) ? 3 : 1)) bad++;
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL wr1024_spacing: got %0d bad gaps expected 0", bad); end
        checks++;
        if (wl_cyc.size() !== 1 || (wl_cyc.size() > 0 && wl_cyc[0] !== 1035)) begin
            failures++;
            $display("FAIL wr1024_last: got %0d pulses first at %0d expected 1 at 1035",
                     wl_cyc.size(), (wl_cyc.size() > 0) ? wl_cyc[0] : -1);
        end

        pkg_rd_addr = BASE; pkg_rd_size = 32'd1024; pkg_rd_areq = 1'b1; t0 = cyc;
        run_until_idle(32'd0, 3000);
        checks++;
        if (rd_cyc.size() !== 1024 || timed_out) begin failures++; $display("FAIL rd1024_beats: got %0d expected 1024", rd_cyc.size()); end
        first = (rd_cyc.size() > 0) ? rd_cyc[0] : -1;
        checks++;
        if (first !== 9) begin failures++; $display("FAIL rd1024_first: got %0d expected 9", first); end
        mism = 0; bad_pos = -1; bad_val = '0;
        for (int i = 0; i < rd_dat.size(); i++)
            if (rd_dat[i] !== 32'(i)) begin
                if (mism == 0) begin bad_pos = i; bad_val = rd_dat[i]; end
                mism++;
            end
        checks++;
        if (mism !== 0) begin failures++; $display("FAIL rd1024_data: %0d wrong, beat %0d got %h expected %h", mism, bad_pos, bad_val, bad_pos); end
        bad = 0;
        for (int i = 1; i < rd_cyc.size(); i++)
            if (rd_cyc[i] - rd_cyc[i-1] != ((i % 256 == 0) ? 3 : 1)) bad++;
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL rd1024_spacing: got %0d bad gaps expected 0", bad); end
        checks++;
        if (rl_cyc.size() !== 1 || (rl_cyc.size() > 0 && rl_cyc[0] !== 1039)) begin
            failures++;
            $display("FAIL rd1024_last: got %0d pulses first at %0d expected 1 at 1039",
                     rl_cyc.size(), (rl_cyc.size() > 0) ? rl_cyc[0] : -1);
        end
    endtask

    task automatic test_same_cycle();
        int ov0;
        ov0 = n_overlap;
        pkg_wr_addr = BASE + 32'h1000; pkg_wr_size = 32'd4; pkg_wr_areq = 1'b1;
        pkg_rd_addr = BASE;            pkg_rd_size = 32'd4; pkg_rd_areq = 1'b1;
        t0 = cyc;
        run_until_idle(32'hA000_0000, 200);
        checks++;
        if (wr_cyc.size() !== 4 || wr_cyc[0] !== 5 || wl_cyc.size() !== 1 || wl_cyc[0] !== 9) begin
            failures++;
            $display("FAIL same_cycle_write: got beats=%0d first=%0d last=%0d expected 4/5/9",
                     wr_cyc.size(), (wr_cyc.size() > 0) ? wr_cyc[0] : -1, (wl_cyc.size() > 0) ? wl_cyc[0] : -1);
        end
        checks++;
        if (rd_cyc.size() !== 4 || rd_cyc[0] !== 18 || rl_cyc.size() !== 1 || rl_cyc[0] !== 22) begin
            failures++;
            $display("FAIL same_cycle_read_timing: got beats=%0d first=%0d last=%0d expected 4/18/22",
                     rd_cyc.size(), (rd_cyc.size() > 0) ? rd_cyc[0] : -1, (rl_cyc.size() > 0) ? rl_cyc[0] : -1);
        end
        checks++;
        if (rd_dat.size() !== 4 || rd_dat[0] !== 32'd0 || rd_dat[1] !== 32'd1 || rd_dat[2] !== 32'd2 || rd_dat[3] !== 32'd3) begin
            failures++;
            $display("FAIL same_cycle_read_data: got %0d words first %h expected 0,1,2,3",
                     rd_dat.size(), (rd_dat.size() > 0) ? rd_dat[0] : 32'hx);
        end
        checks++;
        if (n_overlap !== ov0) begin failures++; $display("FAIL same_cycle_overlap: got %0d overlaps expected 0", n_overlap - ov0); end
    endtask

    task automatic test_drop();
        int d0, w0, l0;
        d0 = n_drop; w0 = n_wr_en; l0 = n_wr_last;
        pkg_wr_addr = BASE + 32'h2000; pkg_wr_size = 32'd16; pkg_wr_areq = 1'b1; t0 = cyc;
        tick(); pkg_wr_areq = 1'b0;
        tick();
        pkg_wr_addr = BASE + 32'h3000; pkg_wr_size = 32'd4; pkg_wr_areq = 1'b1;
        tick();
        pkg_wr_addr = BASE + 32'h3800; pkg_wr_size = 32'd4; pkg_wr_areq = 1'b1;
        tick(); pkg_wr_areq = 1'b0;
        checks++;
        if (req_drop !== 1'b1) begin failures++; $display("FAIL drop_pulse_time: got %b expected 1 at cycle 4", req_drop); end
        run_until_idle(32'hB000_0000, 300);
        checks++;
        if (n_drop - d0 !== 1) begin failures++; $display("FAIL drop_count: got %0d expected 1", n_drop - d0); end
        checks++;
        if (n_wr_en - w0 !== 20 || n_wr_last - l0 !== 2 || timed_out) begin
            failures++;
            $display("FAIL drop_writes: got beats=%0d lasts=%0d expected 20/2", n_wr_en - w0, n_wr_last - l0);
        end
    endtask

    task automatic test_wrap();
        int mism;
        pkg_wr_addr = BASE + 32'h3FF0; pkg_wr_size = 32'd8; pkg_wr_areq = 1'b1; t0 = cyc;
        run_until_idle(32'hC0DE_0000, 200);
        pkg_rd_addr = BASE + 32'h3FF0; pkg_rd_size = 32'd8; pkg_rd_areq = 1'b1; t0 = cyc;
        run_until_idle(32'h0, 200);
        mism = 0;
        for (int i = 0; i < rd_dat.size(); i++)
            if (rd_dat[i] !== 32'hC0DE_0000 + 32'(i)) mism++;
        checks++;
        if (rd_dat.size() !== 8 || mism !== 0) begin
            failures++;
            $display("FAIL wrap_readback: got %0d words %0d wrong expected 8 words C0DE0000..7", rd_dat.size(), mism);
        end
        pkg_rd_addr = BASE; pkg_rd_size = 32'd4; pkg_rd_areq = 1'b1; t0 = cyc;
        run_until_idle(32'h0, 200);
        checks++;
        if (rd_dat.size() !== 4 || rd_dat[0] !== 32'hC0DE_0004 || rd_dat[3] !== 32'hC0DE_0007) begin
            failures++;
            $display("FAIL wrap_low_words: got %0d words first %h expected C0DE0004",
                     rd_dat.size(), (rd_dat.size() > 0) ? rd_dat[0] : 32'hx);
        end
        pkg_rd_addr = BASE + 32'h13; pkg_rd_size = 32'd1; pkg_rd_areq = 1'b1; t0 = cyc;
        run_until_idle(32'h0, 200);
        checks++;
        if (rd_dat.size() !== 1 || rd_dat[0] !== 32'd4) begin
            failures++;
            $display("FAIL wrap_word4_untouched: got %h expected 00000004", (rd_dat.size() > 0) ? rd_dat[0] : 32'hx);
        end
    endtask

    task automatic test_size_zero();
        pkg_rd_addr = BASE; pkg_rd_size = 32'd0; pkg_rd_areq = 1'b1; t0 = cyc;
        run_until_idle(32'h0, 100);
        checks++;
        if (rd_cyc.size() !== 0) begin failures++; $display("FAIL size0_rd_en: got %0d beats expected 0", rd_cyc.size()); end
        checks++;
        if (rl_cyc.size() !== 1 || rl_cyc[0] !== 10) begin
            failures++;
            $display("FAIL size0_last: got %0d pulses at %0d expected 1 at 10", rl_cyc.size(), (rl_cyc.size() > 0) ? rl_cyc[0] : -1);
        end
        checks++;
        if (idle_cyc !== 11 || timed_out) begin failures++; $display("FAIL size0_busy_drop: got %0d expected 11", idle_cyc); end
    endtask

    task automatic test_reset_mid_read();
        int seen, rl0;
        seen = 0;
        pkg_rd_addr = BASE; pkg_rd_size = 32'd16; pkg_rd_areq = 1'b1; t0 = cyc;
        for (int i = 0; i < 40 && seen < 3; i++) begin
            tick();
            pkg_rd_areq = 1'b0;
            if (pkg_rd_en) seen++;
        end
        checks++;
        if (seen !== 3) begin failures++; $display("FAIL midrst_start: got %0d beats expected 3", seen); end
        rl0 = n_rd_last;
        #2 ui_rstn = 1'b0;
        #1;
        checks++;
        if ({pkg_rd_en, pkg_rd_last, busy} !== 3'b000 || pkg_rd_data !== 32'h0) begin
            failures++;
            $display("FAIL midrst_immediate: got en/last/busy=%b data=%h expected 000/00000000",
                     {pkg_rd_en, pkg_rd_last, busy}, pkg_rd_data);
        end
        tick(); tick();
        ui_rstn = 1'b1;
        tick();
        checks++;
        if (n_rd_last !== rl0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_quiet: got lasts=%0d busy=%b expected 0/0", n_rd_last - rl0, busy);
        end
        pkg_wr_addr = BASE + 32'h20; pkg_wr_size = 32'd2; pkg_wr_areq = 1'b1; t0 = cyc;
        run_until_idle(32'hD000_0000, 100);
        pkg_rd_addr = BASE + 32'h20; pkg_rd_size = 32'd2; pkg_rd_areq = 1'b1; t0 = cyc;
        run_until_idle(32'h0, 100);
        checks++;
        if (rd_dat.size() !== 2 || rd_dat[0] !== 32'hD000_0000 || rd_dat[1] !== 32'hD000_0001 ||
            rd_cyc[0] !== 9 || rl_cyc.size() !== 1) begin
            failures++;
            $display("FAIL midrst_recover: got %0d words first %h at %0d expected D0000000 at 9",
                     rd_dat.size(), (rd_dat.size() > 0) ? rd_dat[0] : 32'hx, (rd_cyc.size() > 0) ? rd_cyc[0] : -1);
        end
    endtask

    initial begin
        test_reset();
        test_long_burst();
        test_same_cycle();
        test_drop();
        test_wrap();
        test_size_zero();
        test_reset_mid_read();
        checks++;
        if (n_overlap !== 0) begin failures++; $display("FAIL overlap_total: got %0d expected 0", n_overlap); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fdma_pkg_ram_responder.md
Name: fdma_pkg_ram_responder

Overview:
Responder end of the FDMA package interface: accepts pkg_wr/pkg_rd requests from a user-side initiator and serves them from on-chip block RAM instead of PS DDR. Drives the per-beat strobes, read data and completion pulses with programmable latency and burst gaps, mimicking the real FDMA/AXI timing. Used for DDR-less bring-up and as the slave model in initiator test benches.

Parameters:
MEM_AW, 12, word-address width of internal RAM (depth 2^MEM_AW x 32 bits)
DDR_BASE, 32'h1000000, byte base subtracted from request addresses
WR_LAT, 4, cycles from write acceptance to first pkg_wr_en (>=1)
RD_LAT, 8, cycles from read acceptance to first pkg_rd_en (>=2)
BURST_LEN, 256, beats per burst before an inserted gap (>=1)
GAP_CYC, 2, idle cycles between bursts (0 = none)

Ports:
ui_clk  in  1  clock
ui_rstn  in  1  asynchronous active-low reset
pkg_wr_addr  in  32  write byte address, sampled with pkg_wr_areq
pkg_wr_areq  in  1  write request, one-cycle pulse
pkg_wr_size  in  32  write length in 32-bit beats, sampled with areq
pkg_wr_data  in  32  write data, sampled when pkg_wr_en=1
pkg_wr_en  out  1  write beat strobe
pkg_wr_last  out  1  write completion pulse
pkg_rd_addr  in  32  read byte address, sampled with pkg_rd_areq
pkg_rd_areq  in  1  read request, one-cycle pulse
pkg_rd_size  in  32  read length in beats, sampled with areq
pkg_rd_data  out  32  read data, valid when pkg_rd_en=1
pkg_rd_en  out  1  read beat strobe
pkg_rd_last  out  1  read completion pulse
busy  out  1  engine not in IDLE or request pending
req_drop  out  1  one-cycle pulse: request lost (see below)

Behaviour:
- Reset (async assert, sync release): state IDLE, pending flags clear, all outputs 0 (pkg_rd_data 0). RAM contents not reset.
- Request capture: areq high -> addr/size latched into per-direction pending register, pending flag set. areq while that direction's flag already set -> request dropped, req_drop pulses next cycle, original pending kept.
- Dispatch from IDLE: write pending has priority over read pending; same-cycle wr+rd areq -> write served first, read served after write's last. Pending flag clears on dispatch.
- Word index = ((addr - DDR_BASE) >> 2) mod 2^MEM_AW; addr[1:0] ignored; index increments per beat, wraps at 2^MEM_AW - 1 -> 0.
- States: IDLE, WR_WAIT, WR_DATA, WR_GAP, WR_DONE, RD_WAIT, RD_DATA, RD_GAP, RD_DONE.
- WR_WAIT: WR_LAT cycles after dispatch cycle, then WR_DATA. WR_DATA: pkg_wr_en=1 each cycle; RAM[index] <= pkg_wr_data that cycle. After BURST_LEN beats with beats remaining and GAP_CYC>0 -> WR_GAP (en=0 for GAP_CYC cycles) -> WR_DATA. After final beat -> WR_DONE: pkg_wr_last=1 exactly one cycle, cycle after last en -> IDLE.
- Read identical with RD_LAT; RAM read is registered: address issued one cycle ahead so pkg_rd_data is valid in the same cycle as pkg_rd_en. pkg_rd_data holds last value when en=0. pkg_rd_last one cycle after final rd_en.
- size=0: no en beats; last pulses WR_LAT/RD_LAT+1 cycles after dispatch.
- Beat counter 32 bits; en never asserted on a last cycle; en and last of opposite directions never overlap.
- Read of address just written in the preceding transaction returns new data (no bypass needed; serialization guarantees it).
- busy = (state != IDLE) | any pending flag.

Test Plan:
- Write 1024 beats, data 0..1023, addr DDR_BASE -> 1024 wr_en, first 5 cycles after areq, gaps of 2 after beats 256/512/768, single wr_last; then read 1024 -> rd_data 0..1023 in order, single rd_last.
- Same-cycle wr_areq (addr DDR_BASE+0x1000, size 4) and rd_areq (DDR_BASE, size 4) -> write completes first, read starts after wr_last, returns previously written words.
- Second wr_areq during an active write with pending already set -> req_drop pulses once; only two writes execute.
- Write size 8 at word index 4092 (MEM_AW=12) -> words land at 4092..4095, 0..3; read-back identical.
- size=0 read -> no rd_en, rd_last pulse RD_LAT+1 cycles after dispatch, busy drops next cycle.
- ui_rstn asserted mid read burst -> rd_en, rd_last, busy go 0 immediately; after release, a new request executes normally.
